// File: rtl/spi_slave.sv
// Mode-0 MSB-first SPI slave: oversamples the master's pins on sysClk, exposes a
// byte-level rx strobe/ack handshake and a double-buffered miso transmit path.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sysClk,
    input  logic                  reset,
    input  logic                  spiClk_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] SIdle  = 2'd0;
    localparam logic [1:0] SShift = 2'd1;
    localparam logic [1:0] SDone  = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
    logic                   sclk_prev, ss_prev;
    logic                   sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_rise, sclk_fall, ss_fall;

    logic [1:0]             state;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  tx_buf, tx_shift, rx_shift;
    logic                   tx_full, tx_shift_vld;
    logic                   seen_rise, word_started, rx_pending;
    logic [DATA_WIDTH-1:0]  next_tx;
    logic                   next_tx_vld;

    // ss_n synchronizer resets to the deselected level so a low pin at reset release reads as a fall
    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            sclk_sr   <= '0;
            ss_sr     <= '1;
            mosi_sr   <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], spiClk_i};
            ss_sr     <= {ss_sr[SYNC_STAGES-2:0], ss_n_i};
            mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi_i};
            sclk_prev <= sclk_sync;
            ss_prev   <= ss_sync;
        end
    end

    assign sclk_sync = sclk_sr[SYNC_STAGES-1];
    assign ss_sync   = ss_sr[SYNC_STAGES-1];
    assign mosi_sync = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise = !sclk_prev && sclk_sync;
    assign sclk_fall = sclk_prev && !sclk_sync;
    assign ss_fall   = ss_prev && !ss_sync;

    // Word handed to the shift register on a load/reload; a same-cycle tx_load bypasses the buffer
    always_comb begin
        next_tx     = '0;
        next_tx_vld = 1'b0;
        if (tx_load) begin
            next_tx     = tx_byte;
            next_tx_vld = 1'b1;
        end else if (tx_full) begin
            next_tx     = tx_buf;
            next_tx_vld = 1'b1;
        end
    end

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            state        <= SIdle;
            bit_cnt      <= CNT_MAX;
            tx_buf       <= '0;
            tx_full      <= 1'b0;
            tx_shift     <= '0;
            tx_shift_vld <= 1'b0;
            rx_shift     <= '0;
            seen_rise    <= 1'b0;
            word_started <= 1'b0;
            rx_pending   <= 1'b0;
            miso         <= 1'b0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_ack) begin
                rx_pending <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (tx_load) begin
                tx_buf  <= tx_byte;
                tx_full <= 1'b1;
            end

            case (state)
                SIdle: begin
                    miso <= 1'b0;
                    if (ss_fall) begin
                        tx_shift     <= next_tx;
                        tx_shift_vld <= next_tx_vld;
                        tx_full      <= 1'b0;
                        miso         <= next_tx[DATA_WIDTH-1];
                        bit_cnt      <= CNT_MAX;
                        rx_shift     <= '0;
                        seen_rise    <= 1'b0;
                        word_started <= 1'b0;
                        state        <= SShift;
                    end
                end

                SShift: begin
                    if (ss_sync) begin
                        state    <= SIdle;
                        miso     <= 1'b0;
                        bit_cnt  <= CNT_MAX;
                        rx_shift <= '0;
                        // An untouched word goes back to the empty buffer so it is sent next frame
                        if (!word_started && tx_shift_vld && !tx_full && !tx_load) begin
                            tx_buf  <= tx_shift;
                            tx_full <= 1'b1;
                        end
                        tx_shift_vld <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift     <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
                        seen_rise    <= 1'b1;
                        word_started <= 1'b1;
                        if (bit_cnt == '0) begin
                            state <= SDone;
                        end else begin
                            bit_cnt <= bit_cnt - CW'(1);
                        end
                    end else if (sclk_fall && seen_rise) begin
                        miso <= tx_shift[bit_cnt];
                    end
                end

                SDone: begin
                    rx_byte    <= rx_shift;
                    rx_valid   <= 1'b1;
                    rx_pending <= 1'b1;
                    if (rx_pending && !rx_ack) begin
                        rx_overrun <= 1'b1;
                    end
                    tx_shift     <= next_tx;
                    tx_shift_vld <= next_tx_vld;
                    tx_full      <= 1'b0;
                    bit_cnt      <= CNT_MAX;
                    word_started <= 1'b0;
                    if (ss_sync) begin
                        state <= SIdle;
                        miso  <= 1'b0;
                    end else begin
                        state <= SShift;
                    end
                end

                default: state <= SIdle;
            endcase
        end
    end

    assign tx_ready = !tx_full;
    assign busy     = (state != SIdle);

endmodule
